// File: rtl/turbo_pkg.sv
// Shared trellis definition for the 4-state RSC code (feedback 7, feedforward 5).
// The encoder and the Viterbi decoder both use these helpers.
package turbo_pkg;

    typedef logic [1:0] rsc_state_t;

    localparam int N_STATES = 4;
    localparam int TAIL_LEN = 2;

    typedef enum logic [1:0] {
        DEC_ACS,
        DEC_TRACE,
        DEC_OUT
    } dec_fsm_t;

    // State is {r1,r2}; feedback a = u^r1^r2 shifts in at r1.
    function automatic rsc_state_t rsc_next_state(input rsc_state_t s, input logic u);
        logic a;
        a = u ^ s[1] ^ s[0];
        return {a, s[1]};
    endfunction

    function automatic logic rsc_parity(input rsc_state_t s, input logic u);
        logic a;
        a = u ^ s[1] ^ s[0];
        return a ^ s[0];
    endfunction

endpackage

// File: rtl/rsc_acs_unit.sv
// Combinational add-compare-select for one trellis step of the 4-state RSC code,
// with min-subtraction so metrics stay small.
module rsc_acs_unit
    import turbo_pkg::*;
#(
    parameter int PM_W = 5
) (
    input  logic [N_STATES-1:0][PM_W-1:0] pm_in,
    input  logic                          in_sys,
    input  logic                          in_par,
    output logic [N_STATES-1:0][PM_W-1:0] pm_out,
    output logic [N_STATES-1:0]           dec
);

    logic [N_STATES-1:0][PM_W-1:0] pm_sel;
    logic [PM_W-1:0]               pm_min;

    function automatic logic [1:0] bmetric(input rsc_state_t p, input logic u,
                                           input logic rs, input logic rp);
        return {1'b0, u ^ rs} + {1'b0, rsc_parity(p, u) ^ rp};
    endfunction

    // Next state {a,x} is reached from {x,d}; the input on that branch is a^x^d.
    for (genvar ns = 0; ns < N_STATES; ns++) begin : g_ns
        localparam logic [1:0] NS = 2'(ns);
        localparam logic [1:0] P0 = {NS[0], 1'b0};
        localparam logic [1:0] P1 = {NS[0], 1'b1};
        localparam logic       U0 = NS[1] ^ NS[0];

        logic [PM_W-1:0] c0, c1;

        assign c0          = pm_in[P0] + PM_W'(bmetric(P0, U0, in_sys, in_par));
        assign c1          = pm_in[P1] + PM_W'(bmetric(P1, ~U0, in_sys, in_par));
        assign dec[ns]     = c1 < c0;
        assign pm_sel[ns]  = dec[ns] ? c1 : c0;
        assign pm_out[ns]  = pm_sel[ns] - pm_min;
    end

    always_comb begin
        pm_min = pm_sel[0];
        for (int i = 1; i < N_STATES; i++) begin
            if (pm_sel[i] < pm_min) pm_min = pm_sel[i];
        end
    end

endmodule

// File: rtl/rsc_viterbi_dec.sv
// Hard-decision Viterbi decoder for one terminated RSC frame: ACS per received pair,
// traceback from state 00, then streams the decoded bits in order.
module rsc_viterbi_dec
    import turbo_pkg::*;
#(
    parameter int FRAME_LEN = 64,
    parameter int PM_W      = 5,
    parameter int PM_INIT   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_sys,
    input  logic in_par,
    output logic out_valid,
    input  logic out_ready,
    output logic out_bit,
    output logic out_last
);

    localparam int STEPS  = FRAME_LEN + TAIL_LEN;
    localparam int STEP_W = $clog2(STEPS);
    localparam int IDX_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [N_STATES-1:0][PM_W-1:0] PM_RESET =
        {PM_W'(PM_INIT), PM_W'(PM_INIT), PM_W'(PM_INIT), PM_W'(0)};

    dec_fsm_t                      fsm, fsm_nxt;
    logic [STEP_W-1:0]             step;
    logic [IDX_W-1:0]              idx;
    logic [N_STATES-1:0][PM_W-1:0] pm, pm_nxt;
    logic [N_STATES-1:0]           dec;
    logic [N_STATES-1:0]           surv [STEPS];
    logic [FRAME_LEN-1:0]          bits;
    rsc_state_t                    tb_state;
    logic                          accept, out_fire, tb_d, tb_u;

    rsc_acs_unit #(.PM_W(PM_W)) u_acs (
        .pm_in  (pm),
        .in_sys (in_sys),
        .in_par (in_par),
        .pm_out (pm_nxt),
        .dec    (dec)
    );

    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign out_bit  = out_valid && bits[idx];
    assign out_last = out_valid && (idx == IDX_W'(FRAME_LEN - 1));
    assign tb_d     = surv[step][tb_state];
    assign tb_u     = tb_state[1] ^ tb_state[0] ^ tb_d;

    always_ff @(posedge clk) begin
        if (rst) fsm <= DEC_ACS;
        else     fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt   = fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (fsm)
            DEC_ACS: begin
                in_ready = 1'b1;
                if (in_valid && step == STEP_W'(STEPS - 1)) fsm_nxt = DEC_TRACE;
            end
            DEC_TRACE: begin
                if (step == '0) fsm_nxt = DEC_OUT;
            end
            DEC_OUT: begin
                out_valid = 1'b1;
                if (out_ready && idx == IDX_W'(FRAME_LEN - 1)) fsm_nxt = DEC_ACS;
            end
            default: fsm_nxt = DEC_ACS;
        endcase
    end

    // The step counter doubles as the traceback index, so it parks at the last
    // trellis step when the final tail pair is accepted and counts down from there.
    always_ff @(posedge clk) begin
        if (rst) begin
            step     <= '0;
            idx      <= '0;
            pm       <= PM_RESET;
            tb_state <= '0;
            bits     <= '0;
        end else begin
            case (fsm)
                DEC_ACS: begin
                    if (accept) begin
                        pm       <= pm_nxt;
                        tb_state <= '0;
                        if (step != STEP_W'(STEPS - 1)) step <= step + 1'b1;
                    end
                end
                DEC_TRACE: begin
                    tb_state <= {tb_state[0], tb_d};
                    if (32'(step) < FRAME_LEN) bits[step[IDX_W-1:0]] <= tb_u;
                    if (step != '0) step <= step - 1'b1;
                    idx <= '0;
                end
                DEC_OUT: begin
                    if (out_fire) begin
                        if (out_last) begin
                            pm   <= PM_RESET;
                            step <= '0;
                            idx  <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) surv[step] <= dec;
    end

endmodule

// File: tb/tb_rsc_viterbi_dec.sv
// Bench for rsc_viterbi_dec: a FRAME_LEN=4 and a FRAME_LEN=64 instance, driven with
// directed and random frames, checked against a bench-side RSC encoder.
module tb_rsc_viterbi_dec;

    localparam int FL0 = 4;
    localparam int FL1 = 64;

    logic clk = 1'b0;
    logic rst;
    logic in_valid[2], in_sys[2], in_par[2], out_ready[2];
    logic in_ready[2], out_valid[2], out_bit[2], out_last[2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    bit rxq[2][$];
    bit lastq[2][$];
    int acc_cyc[2][$];
    int hs_q[2][$];
    int rdy_mode[2];
    int rise_cyc[2];
    int low_cnt[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rsc_viterbi_dec #(.FRAME_LEN(FL0), .PM_W(5), .PM_INIT(8)) u_dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_sys(in_sys[0]), .in_par(in_par[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_bit(out_bit[0]), .out_last(out_last[0])
    );

    rsc_viterbi_dec #(.FRAME_LEN(FL1), .PM_W(5), .PM_INIT(8)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_sys(in_sys[1]), .in_par(in_par[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_bit(out_bit[1]), .out_last(out_last[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference encoder: integer shift register, tail chosen to zero the feedback.
    function automatic void encode(input bit info[$], output bit [1:0] prs[$]);
        int r1 = 0, r2 = 0, a, u;
        prs = {};
        for (int i = 0; i < info.size() + 2; i++) begin
            u = (i < info.size()) ? int'(info[i]) : (r1 ^ r2);
            a = u ^ r1 ^ r2;
            prs.push_back({u[0], 1'(a ^ r2)});
            r2 = r1;
            r1 = a;
        end
    endfunction

    function automatic void rand_info(input int n, output bit info[$]);
        info = {};
        for (int i = 0; i < n; i++) info.push_back(1'($urandom_range(0, 1)));
    endfunction

    // Output side: drives out_ready, records transfers, checks stability while stalled.
    for (genvar k = 0; k < 2; k++) begin : g_mon
        initial begin
            bit stalled, pv, sb, sl;
            int ph;
            stalled = 0; pv = 0; sb = 0; sl = 0; ph = 0;
            out_ready[k] = 1'b1;
            forever begin
                @(negedge clk);
                if (rst) begin
                    stalled = 0;
                    pv      = 0;
                end else begin
                    case (rdy_mode[k])
                        1: begin out_ready[k] = (ph % 4 == 0) || (ph % 4 == 3); ph++; end
                        2: out_ready[k] = 1'($urandom_range(0, 1));
                        default: out_ready[k] = 1'b1;
                    endcase
                    if (!in_ready[k]) low_cnt[k]++;
                    if (out_valid[k] && !pv) rise_cyc[k] = cyc;
                    if (stalled) begin
                        chk("stall_valid", 32'(out_valid[k]), 32'd1);
                        chk("stall_bit", 32'(out_bit[k]), 32'(sb));
                        chk("stall_last", 32'(out_last[k]), 32'(sl));
                    end
                    stalled = 0;
                    if (out_valid[k]) begin
                        if (out_ready[k]) begin
                            rxq[k].push_back(out_bit[k]);
                            lastq[k].push_back(out_last[k]);
                            if (out_last[k]) hs_q[k].push_back(cyc);
                        end else begin
                            stalled = 1;
                            sb = out_bit[k];
                            sl = out_last[k];
                        end
                    end
                    pv = out_valid[k];
                end
            end
        end
    end

    task automatic send(input int k, input bit [1:0] prs[$], input int gap_pct);
        int i = 0, guard = 0;
        while (i < prs.size() && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                in_valid[k] = 1'b0;
            end else begin
                in_valid[k] = 1'b1;
                in_sys[k]   = prs[i][1];
                in_par[k]   = prs[i][0];
                if (in_ready[k]) begin
                    acc_cyc[k].push_back(cyc);
                    i++;
                end
            end
        end
        chk("send_done", 32'(i), 32'(prs.size()));
        @(negedge clk);
        in_valid[k] = 1'b0;
    endtask

    task automatic expect_frame(input int k, input string tag, input bit info[$]);
        int n = info.size(), t = 0, eb = 0, el = 0;
        bit b, l;
        while (rxq[k].size() < n && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_cnt"}, 32'(rxq[k].size()), 32'(n));
        for (int i = 0; i < n && rxq[k].size() > 0; i++) begin
            b = rxq[k].pop_front();
            l = lastq[k].pop_front();
            if (b != info[i]) eb++;
            if (l != (i == n - 1)) el++;
        end
        chk({tag, "_bits"}, 32'(eb), 32'd0);
        chk({tag, "_last"}, 32'(el), 32'd0);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit [1:0] prs[$], cat[$], part[$];
        bit info[$], info_b[$];
        int t, p;

        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0; in_sys[k] = 1'b0; in_par[k] = 1'b0;
            rdy_mode[k] = 0; rise_cyc[k] = 0; low_cnt[k] = 0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_in_ready", 32'(in_ready[k]), 32'd1);
            chk("rst_out_valid", 32'(out_valid[k]), 32'd0);
            chk("rst_out_bit", 32'(out_bit[k]), 32'd0);
            chk("rst_out_last", 32'(out_last[k]), 32'd0);
        end

        // Directed frame plus latency from last accept to out_valid.
        info = '{1, 0, 1, 1};
        prs  = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b01, 2'b11};
        acc_cyc[0] = {};
        send(0, prs, 0);
        expect_frame(0, "dir", info);
        if (acc_cyc[0].size() > 0)
            chk("latency", 32'(rise_cyc[0] - acc_cyc[0][acc_cyc[0].size() - 1]), 32'(FL0 + 3));

        // Same frame, second pair hit by a channel error.
        prs[1] = 2'b00;
        send(0, prs, 0);
        expect_frame(0, "corrupt", info);

        // Stalling downstream with the 1,0,0,1 ready pattern.
        rdy_mode[0] = 1;
        info = '{0, 1, 1, 0};
        encode(info, prs);
        send(0, prs, 0);
        expect_frame(0, "stall", info);

        // Reset after 3 pairs, then a clean frame.
        rdy_mode[0] = 0;
        info = '{1, 1, 0, 1};
        encode(info, prs);
        part = prs[0:2];
        send(0, part, 0);
        pulse_rst();
        chk("rst_mid_in_ready", 32'(in_ready[0]), 32'd1);
        send(0, prs, 0);
        expect_frame(0, "after_rst", info);
        chk("after_rst_empty", 32'(rxq[0].size()), 32'd0);

        // Reset while streaming output.
        rdy_mode[0] = 1;
        send(0, prs, 0);
        t = 0;
        while (!out_valid[0] && t < 100) begin @(negedge clk); t++; end
        chk("rst_out_reached", 32'(out_valid[0]), 32'd1);
        pulse_rst();
        chk("rst_out_valid_drop", 32'(out_valid[0]), 32'd0);
        chk("rst_out_in_ready", 32'(in_ready[0]), 32'd1);
        @(negedge clk);
        rxq[0] = {}; lastq[0] = {}; hs_q[0] = {};

        // Back-to-back frames with in_valid held high through TRACE/OUT.
        rand_info(FL0, info);
        rand_info(FL0, info_b);
        encode(info, cat);
        encode(info_b, prs);
        foreach (prs[i]) cat.push_back(prs[i]);
        acc_cyc[0] = {};
        hs_q[0] = {};
        send(0, cat, 0);
        expect_frame(0, "b2b_a", info);
        expect_frame(0, "b2b_b", info_b);
        if (acc_cyc[0].size() > FL0 + 2 && hs_q[0].size() > 0)
            chk("b2b_resume", 32'(acc_cyc[0][FL0 + 2]), 32'(hs_q[0][0] + 1));
        else
            chk("b2b_records", 32'(hs_q[0].size()), 32'd1);

        // Random short frames, at most one channel error each.
        for (int f = 0; f < 20; f++) begin
            rdy_mode[0] = $urandom_range(0, 2);
            rand_info(FL0, info);
            encode(info, prs);
            if ($urandom_range(0, 1) == 1) begin
                p = $urandom_range(0, FL0 + 1);
                prs[p] = prs[p] ^ (2'b01 << $urandom_range(0, 1));
            end
            send(0, prs, 20);
            expect_frame(0, "rand4", info);
        end

        // FRAME_LEN=64 all-zero frame: in_ready low for 66 TRACE + 64 OUT cycles.
        info = {};
        for (int i = 0; i < FL1; i++) info.push_back(1'b0);
        encode(info, prs);
        low_cnt[1] = 0;
        send(1, prs, 0);
        expect_frame(1, "zero64", info);
        repeat (3) @(negedge clk);
        chk("zero64_busy", 32'(low_cnt[1]), 32'(FL1 + 2 + FL1));

        for (int f = 0; f < 3; f++) begin
            rdy_mode[1] = 2;
            rand_info(FL1, info);
            encode(info, prs);
            p = $urandom_range(0, FL1 + 1);
            prs[p] = prs[p] ^ 2'b10;
            send(1, prs, 10);
            expect_frame(1, "rand64", info);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
